my_eth_ipv4_tcp_dut: RTL and testbench

MY_ETH_IPV4_TCP_DUT -- requirements
Module: my_eth_ipv4_tcp_dut

---
 rtl/my_eth_ipv4_tcp_dut.sv | 216 +++++++++++++++++++++
 tb/tb_my_eth_ipv4_tcp_dut.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_eth_ipv4_tcp_dut.sv
// Ethernet/IPv4/TCP header stripper.
// Parses a fixed 26-byte header (eth dst/src, EtherType, IPv4 src/dst, TCP ports),
// accepts only EtherType 0x0800 frames and forwards bytes 26..end realigned to lane 0.
// Ports:
//   clk, rst_n            - single clock, asynchronous active-low reset
//   s_axis_*              - inbound frame stream (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_*              - outbound payload stream, registered (tdata/tkeep/tvalid/tready/tlast)
module my_eth_ipv4_tcp_dut #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int unsigned N  = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(N) + 1;  // holds 0..N
  localparam int unsigned SW = CW + 1;         // holds 0..2N-1
  localparam logic [8:0] HdrLen = 9'd26;

  typedef enum logic [1:0] {StHdr, StPayload, StFlush, StDrop} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [15:0]           etype_q, etype_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]         res_cnt_q, res_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [N-1:0]          out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  rdy_en_q;

  logic                    in_fire;
  logic                    out_free;
  logic [CW-1:0]           in_bytes;
  logic [DATA_WIDTH-1:0]   in_masked;
  logic [15:0]             etype_cur;
  logic [8:0]              pos_end;
  logic                    hdr_done;
  logic                    etype_ok;
  logic                    take_pl;
  logic [CW-1:0]           pl_start;
  logic [CW-1:0]           pl_bytes;
  logic [DATA_WIDTH-1:0]   pl_data;
  logic [2*DATA_WIDTH-1:0] comb_data;
  logic [SW-1:0]           comb_cnt;
  logic                    flush_need;
  logic                    out_load;

  function automatic logic [N-1:0] keep_mask(input logic [SW-1:0] c);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      m[k] = (SW'(k) < c);
    end
    return m;
  endfunction

  // Byte count of the beat, lane masking and EtherType capture at frame bytes 12/13.
  always_comb begin
    in_bytes  = '0;
    in_masked = '0;
    etype_cur = etype_q;
    for (int k = 0; k < N; k++) begin
      if (s_axis_tkeep[k]) begin
        in_bytes = in_bytes + CW'(1);
        in_masked[8*k +: 8] = s_axis_tdata[8*k +: 8];
        if (9'(cnt_q) + 9'(k) == 9'd12) etype_cur[15:8] = s_axis_tdata[8*k +: 8];
        if (9'(cnt_q) + 9'(k) == 9'd13) etype_cur[7:0]  = s_axis_tdata[8*k +: 8];
      end
    end
  end

  assign out_free      = !out_valid_q || m_axis_tready;
  assign s_axis_tready = rdy_en_q && out_free && (state_q != StFlush);
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  assign pos_end  = 9'(cnt_q) + 9'(in_bytes);
  assign hdr_done = (state_q == StHdr) && (pos_end >= HdrLen);
  assign etype_ok = (etype_cur == 16'h0800);
  assign take_pl  = in_fire && ((state_q == StPayload) || (hdr_done && etype_ok));

  // On the header-completing beat the payload starts mid-beat; afterwards at lane 0.
  assign pl_start = (state_q == StHdr) ? CW'(HdrLen - 9'(cnt_q)) : '0;
  assign pl_bytes = take_pl ? (in_bytes - pl_start) : '0;
  assign pl_data  = take_pl ? (in_masked >> {pl_start, 3'b000}) : '0;

  // Residual bytes first, then this beat's payload; lanes past comb_cnt stay zero.
  assign comb_data = {{DATA_WIDTH{1'b0}}, res_q} |
                     ({{DATA_WIDTH{1'b0}}, pl_data} << {res_cnt_q, 3'b000});
  assign comb_cnt   = SW'(res_cnt_q) + SW'(pl_bytes);
  assign flush_need = comb_cnt > SW'(N);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StHdr;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (in_fire) begin
          if (s_axis_tlast)  state_d = StHdr;
          else if (hdr_done) state_d = etype_ok ? StPayload : StDrop;
        end
      end
      StPayload: begin
        if (in_fire && s_axis_tlast) state_d = flush_need ? StFlush : StHdr;
      end
      StFlush: begin
        if (out_free) state_d = StHdr;
      end
      StDrop: begin
        if (in_fire && s_axis_tlast) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    cnt_d       = cnt_q;
    etype_d     = etype_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_load    = 1'b0;

    if (m_axis_tready) out_valid_d = 1'b0;

    if ((state_q == StHdr) && in_fire) begin
      etype_d = etype_cur;
      cnt_d   = (s_axis_tlast || hdr_done) ? 5'd0 : 5'(pos_end);
    end

    if (take_pl) begin
      if (comb_cnt >= SW'(N)) begin
        out_load   = 1'b1;
        out_data_d = comb_data[DATA_WIDTH-1:0];
        out_keep_d = '1;
        out_last_d = s_axis_tlast && !flush_need;
        res_d      = comb_data[2*DATA_WIDTH-1:DATA_WIDTH];
        res_cnt_d  = CW'(comb_cnt - SW'(N));
      end else if (s_axis_tlast) begin
        if (comb_cnt != '0) begin
          out_load   = 1'b1;
          out_data_d = comb_data[DATA_WIDTH-1:0];
          out_keep_d = keep_mask(comb_cnt);
          out_last_d = 1'b1;
        end
        res_d     = '0;
        res_cnt_d = '0;
      end else begin
        res_d     = comb_data[DATA_WIDTH-1:0];
        res_cnt_d = CW'(comb_cnt);
      end
    end

    if ((state_q == StFlush) && out_free) begin
      out_load   = 1'b1;
      out_data_d = res_q;
      out_keep_d = keep_mask(SW'(res_cnt_q));
      out_last_d = 1'b1;
      res_d      = '0;
      res_cnt_d  = '0;
    end

    if (out_load) out_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      etype_q     <= '0;
      res_q       <= '0;
      res_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      etype_q     <= etype_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      rdy_en_q    <= 1'b1;  // keeps tready low until the first edge after reset release
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_my_eth_ipv4_tcp_dut.sv
`timescale 1ns/1ps
module tb_my_eth_ipv4_tcp_dut;

  localparam int DW = 64;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [NB-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [NB-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  always #5 clk = ~clk;

  my_eth_ipv4_tcp_dut #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  beat_t       sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  fbuf [0:2047];
  int          flen = 0;
  logic [15:0] cur_et = 16'h0;
  int          ready_mode = 0;
  bit          chk_ready = 1'b0;
  bit          saw_ready_low = 1'b0;
  int          out_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Header: 02:00:00:00:00:02 <- 02:00:00:00:00:01, C0A80001 -> C0A80002, 50000 -> 443.
  task automatic build_frame(input logic [15:0] et, input int len, input logic [7:0] base,
                             input logic [7:0] step);
    logic [207:0] h;
    h = {48'h020000000002, 48'h020000000001, et, 32'hC0A80001, 32'hC0A80002,
         16'hC350, 16'h01BB};
    cur_et = et;
    flen   = len;
    for (int i = 0; i < len; i++) begin
      if (i < 26) fbuf[i] = h[8*(25-i) +: 8];
      else        fbuf[i] = base + step * 8'(i - 26);
    end
  endtask

  // Reference: payload bytes 26..end chopped into NB-byte beats from lane 0.
  task automatic push_expected();
    beat_t e;
    if (flen > 26 && cur_et == 16'h0800) begin
      for (int i = 26; i < flen; i += NB) begin
        e = '0;
        for (int j = 0; j < NB; j++) begin
          if (i + j < flen) begin
            e.d[8*j +: 8] = fbuf[i+j];
            e.k[j] = 1'b1;
          end
        end
        e.l = (i + NB >= flen);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int w;
    w = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && w < 400) begin
      w++;
      @(negedge clk);
    end
    if (!s_tready) check("s_tready_timeout", {63'b0, s_tready}, 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic frame_beat(input int b, output logic [DW-1:0] d, output logic [NB-1:0] k,
                            output logic l);
    d = '0;
    k = '0;
    for (int j = 0; j < NB; j++) begin
      if (b*NB + j < flen) begin
        d[8*j +: 8] = fbuf[b*NB + j];
        k[j] = 1'b1;
      end
    end
    l = ((b + 1) * NB >= flen);
  endtask

  task automatic send_frame();
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
    push_expected();
    for (int b = 0; b * NB < flen; b++) begin
      frame_beat(b, d, k, l);
      send_beat(d, k, l);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_tvalid"}, {63'b0, m_tvalid}, 64'd0);
    check({tag, "_m_tdata"},  m_tdata, 64'd0);
    check({tag, "_m_tkeep"},  {56'b0, m_tkeep}, 64'd0);
    check({tag, "_m_tlast"},  {63'b0, m_tlast}, 64'd0);
    check({tag, "_s_tready"}, {63'b0, s_tready}, 64'd0);
  endtask

  // Sink ready pattern: 0 = always ready, 1 = low 3 of every 5 cycles, 2 = never ready.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      case (ready_mode)
        1:       m_tready = ((c % 5) < 2);
        2:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every accepted output beat with the scoreboard head.
  initial begin
    beat_t         e;
    logic          hold;
    logic [DW-1:0] hd;
    logic [NB-1:0] hk;
    logic          hl;
    hold = 1'b0;
    hd = '0;
    hk = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (chk_ready) check("s_tready_high_on_drop", {63'b0, s_tready}, 64'd1);
        if (!s_tready) saw_ready_low = 1'b1;
        if (hold) begin
          check("stall_hold_valid", {63'b0, m_tvalid}, 64'd1);
          check("stall_hold_data", m_tdata, hd);
          check("stall_hold_keep_last", {55'b0, m_tkeep, m_tlast}, {55'b0, hk, hl});
        end
        hold = m_tvalid && !m_tready;
        hd = m_tdata;
        hk = m_tkeep;
        hl = m_tlast;
        if (m_tvalid && m_tready) begin
          out_beats++;
          if (sb.size() == 0) begin
            check("unexpected_out_beat", {63'b0, m_tvalid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_tdata", m_tdata, e.d);
            check("out_tkeep", {56'b0, m_tkeep}, {56'b0, e.k});
            check("out_tlast", {63'b0, m_tlast}, {63'b0, e.l});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
    int            beats_before;

    // Reset state and tready release timing.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tready_before_first_edge", {63'b0, s_tready}, 64'd0);
    @(posedge clk);
    #1;
    check("tready_after_first_edge", {63'b0, s_tready}, 64'd1);

    // 34-byte frame, payload 00..07 -> one full beat with tlast.
    build_frame(16'h0800, 34, 8'h00, 8'h01);
    send_frame();
    // 29-byte frame, payload AA BB CC -> tkeep 0x07.
    build_frame(16'h0800, 29, 8'hAA, 8'h11);
    send_frame();
    wait_drain();

    // Dropped frames: IPv6 EtherType, 20-byte runt, 26-byte header only.
    chk_ready = 1'b1;
    build_frame(16'h86DD, 40, 8'h30, 8'h01);
    send_frame();
    build_frame(16'h0800, 20, 8'h00, 8'h01);
    send_frame();
    build_frame(16'h0800, 26, 8'h00, 8'h01);
    send_frame();
    repeat (3) @(posedge clk);
    #1;
    chk_ready = 1'b0;

    // Back-to-back 34-byte frames.
    build_frame(16'h0800, 34, 8'h00, 8'h01);
    send_frame();
    build_frame(16'h0800, 34, 8'h10, 8'h01);
    send_frame();
    wait_drain();

    // 1486-byte frame under output backpressure: 182 full beats + one 4-byte beat.
    saw_ready_low = 1'b0;
    beats_before  = out_beats;
    ready_mode    = 1;
    build_frame(16'h0800, 1486, 8'h00, 8'h01);
    send_frame();
    wait_drain();
    ready_mode = 0;
    check("long_frame_beat_count", 64'(out_beats - beats_before), 64'd183);
    check("tready_dropped_under_stall", {63'b0, saw_ready_low}, 64'd1);

    // Reset during beat 2 of a frame, then a clean 34-byte frame.
    build_frame(16'h0800, 34, 8'h55, 8'h01);
    frame_beat(0, d, k, l);
    send_beat(d, k, l);
    frame_beat(1, d, k, l);
    send_beat(d, k, l);
    frame_beat(2, d, k, l);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_frame(16'h0800, 34, 8'h00, 8'h01);
    send_frame();
    wait_drain();

    // Reset while an output beat is stalled: it must be discarded.
    ready_mode = 2;
    @(posedge clk);
    #1;
    build_frame(16'h0800, 29, 8'hAA, 8'h11);
    send_frame();
    repeat (3) @(posedge clk);
    #1;
    check("stalled_beat_pending", {63'b0, m_tvalid}, 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_outputs_zero("stalled_reset");
    ready_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_frame(16'h0800, 34, 8'h20, 8'h01);
    send_frame();
    wait_drain();

    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
